// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory sequencer.
package mem_access_ctrl_pkg;

  localparam int unsigned DATA_LEN = 64;

  // Access size encodings carried down the pipeline.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Natural alignment: the low log2(size) address bits must be zero.
  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] a);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = (a[0] == 1'b0);
      SIZE_W:  ok = (a[1:0] == 2'b00);
      default: ok = (a == 3'b000);
    endcase
    return ok;
  endfunction

  // Byte lanes touched by an access of the given size at byte offset a.
  function automatic logic [7:0] byte_strobe(input logic [1:0] size, input logic [2:0] a);
    logic [7:0] s;
    case (size)
      SIZE_B:  s = 8'h01 << a;
      SIZE_H:  s = 8'h03 << a;
      SIZE_W:  s = 8'h0F << a;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load data alignment: shift the addressed bytes down, then sign/zero extend.
module mem_access_ctrl_load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [2:0]          a,
  input  logic [1:0]          size,
  input  logic                sext,
  output logic [DATA_LEN-1:0] data
);

  logic [DATA_LEN-1:0] shifted;

  // Right-justify the addressed bytes and extend to the full width.
  always_comb begin
    shifted = rdata >> {a, 3'b000};
    data    = shifted;
    case (size)
      SIZE_B:  data = {{56{sext & shifted[7]}},  shifted[7:0]};
      SIZE_H:  data = {{48{sext & shifted[15]}}, shifted[15:0]};
      SIZE_W:  data = {{32{sext & shifted[31]}}, shifted[31:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: one outstanding req/ack access, with
// store alignment, load extraction and a pipeline hold while busy.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rmem_i,
  input  logic                wmem_i,
  input  logic [DATA_LEN-1:0] addr_i,
  input  logic [DATA_LEN-1:0] wdata_i,
  input  logic [1:0]          size_i,
  input  logic                sext_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [7:0]          mem_wstrb_o,
  input  logic                mem_ack_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic [DATA_LEN-1:0] rdata_o,
  output logic                hold_o,
  output logic                err_o
);

  // Counter holds the index of the current REQ cycle (0..TIMEOUT-1).
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [7:0]          wstrb_q, wstrb_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          a_q, a_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic                busy;
  logic [DATA_LEN-1:0] load_data;

  mem_access_ctrl_load_align u_load_align (
    .rdata (mem_rdata_i),
    .a     (a_q),
    .size  (size_q),
    .sext  (sext_q),
    .data  (load_data)
  );

  // Next-state logic for the FSM and all registered outputs.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    a_d     = a_q;
    size_d  = size_q;
    sext_d  = sext_q;
    busy    = 1'b0;
    case (state_q)
      StIdle: begin
        if (rmem_i || wmem_i) begin
          busy = 1'b1;
          if ((rmem_i && wmem_i) || !is_aligned(size_i, addr_i[2:0])) begin
            // Rejected access: no bus traffic, just an error in DONE.
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            req_d   = 1'b1;
            we_d    = wmem_i;
            addr_d  = {addr_i[DATA_LEN-1:3], 3'b000};
            wdata_d = wdata_i << {addr_i[2:0], 3'b000};
            wstrb_d = byte_strobe(size_i, addr_i[2:0]);
            a_d     = addr_i[2:0];
            size_d  = size_i;
            sext_d  = sext_i;
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        busy = 1'b1;
        if (mem_ack_i) begin
          // Ack beats a simultaneous timeout.
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
          if (!we_q) begin
            rdata_d = load_data;
          end
        end else if (cnt_q == CntLast) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = wstrb_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign hold_o      = busy && !rst;

endmodule
